decimal_entry_to_binary: RTL and testbench

- Sequential decimal-entry block, the input-side counterpart of the binary-to-7-segment display path.
- Accepts up to three decimal digit strobes plus sign, clear and enter controls from a keypad/switch front end.
- Converts the entered value to a W-bit signed number, in either signed-magnitude or two's-complement encoding.
- Exposes the entered BCD digits and sign so the display path can echo entry in progress.

---
 rtl/decimal_entry_to_binary_if.sv | 33 +++
 rtl/decimal_entry_to_binary.sv | 141 ++++++++++++++
 tb/tb_decimal_entry_to_binary.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/decimal_entry_to_binary_if.sv
// Keypad entry bundle: digit/sign/clear/enter strobes in,
// converted word, status and BCD echo out.
interface decimal_entry_to_binary_if #(
  parameter int W = 11
);
  logic [3:0]   digit;
  logic         digit_valid;
  logic         negate;
  logic         clear;
  logic         enter;
  logic         encoding;
  logic [W-1:0] n;
  logic         valid;
  logic         busy;
  logic [11:0]  bcd;
  logic [1:0]   count;
  logic         negative;
  logic         overflow;

  modport master (
    output digit, digit_valid, negate,
    output clear, enter, encoding,
    input  n, valid, busy, bcd,
    input  count, negative, overflow
  );

  modport slave (
    input  digit, digit_valid, negate,
    input  clear, enter, encoding,
    output n, valid, busy, bcd,
    output count, negative, overflow
  );
endinterface

// File: rtl/decimal_entry_to_binary.sv
// Decimal keypad entry (up to 3 BCD digits + sign) converted to a
// W-bit signed word. Ports: clk, rst (async high), io (slave bundle).
module decimal_entry_to_binary #(
  parameter int W = 11
) (
  input logic                      clk,
  input logic                      rst,
  decimal_entry_to_binary_if.slave io
);

  typedef enum logic {ENTRY, CONVERT} state_t;

  state_t       state_q, state_d;
  logic [1:0]   step_q, step_d;
  logic [9:0]   acc_q, acc_d;
  logic         enc_q, enc_d;
  logic [W-1:0] n_q, n_d;
  logic         valid_q, valid_d;
  logic [11:0]  bcd_q, bcd_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         neg_q, neg_d;
  logic         ovf_q, ovf_d;

  logic [3:0]   dsel;
  logic [9:0]   acc_nx;
  logic [W-1:0] mag;
  logic         neg_r;

  always_comb begin
    unique case (step_q)
      2'd0:    dsel = bcd_q[11:8];
      2'd1:    dsel = bcd_q[7:4];
      default: dsel = bcd_q[3:0];
    endcase
  end

  // acc*10 as shift-and-add; acc <= 99 here so 10 bits hold it
  assign acc_nx = (acc_q << 3) + (acc_q << 1)
                + {6'd0, dsel};
  assign mag    = {{(W-10){1'b0}}, acc_nx};
  // negative zero collapses to plain zero
  assign neg_r  = neg_q && (acc_nx != 10'd0);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    acc_d   = acc_q;
    enc_d   = enc_q;
    n_d     = n_q;
    valid_d = 1'b0;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      ENTRY: begin
        if (io.clear) begin
          bcd_d = '0;
          cnt_d = '0;
          neg_d = 1'b0;
          ovf_d = 1'b0;
        end else if (io.enter) begin
          enc_d   = io.encoding;
          acc_d   = '0;
          step_d  = '0;
          state_d = CONVERT;
        end else if (io.negate) begin
          neg_d = ~neg_q;
        end else if (io.digit_valid) begin
          if (io.digit <= 4'd9) begin
            if (cnt_q == 2'd3) begin
              ovf_d = 1'b1;
            end else begin
              bcd_d = {bcd_q[7:0], io.digit};
              cnt_d = cnt_q + 2'd1;
            end
          end
        end
      end
      CONVERT: begin
        if (io.clear) begin
          bcd_d   = '0;
          cnt_d   = '0;
          neg_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = ENTRY;
        end else begin
          acc_d  = acc_nx;
          step_d = step_q + 2'd1;
          if (step_q == 2'd2) begin
            if (enc_q)
              n_d = neg_r ? (~mag + 1'b1) : mag;
            else
              n_d = {neg_r, mag[W-2:0]};
            valid_d = 1'b1;
            bcd_d   = '0;
            cnt_d   = '0;
            neg_d   = 1'b0;
            state_d = ENTRY;
          end
        end
      end
      default: state_d = ENTRY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ENTRY;
      step_q  <= '0;
      acc_q   <= '0;
      enc_q   <= 1'b0;
      n_q     <= '0;
      valid_q <= 1'b0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      enc_q   <= enc_d;
      n_q     <= n_d;
      valid_q <= valid_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
    end
  end

  assign io.n        = n_q;
  assign io.valid    = valid_q;
  assign io.busy     = (state_q == CONVERT);
  assign io.bcd      = bcd_q;
  assign io.count    = cnt_q;
  assign io.negative = neg_q;
  assign io.overflow = ovf_q;

endmodule

// File: tb/tb_decimal_entry_to_binary.sv
// Directed bench for decimal_entry_to_binary: hand-computed
// results for entry, encodings, overflow, abort and reset.
module tb_decimal_entry_to_binary;

  localparam int W = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_ok  = 0;

  decimal_entry_to_binary_if #(.W(W)) io ();

  decimal_entry_to_binary #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .io  (io.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h, expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    io.digit       = d;
    io.digit_valid = 1'b1;
    tick();
    io.digit_valid = 1'b0;
  endtask

  task automatic neg_key();
    io.negate = 1'b1;
    tick();
    io.negate = 1'b0;
  endtask

  task automatic clr_key();
    io.clear = 1'b1;
    tick();
    io.clear = 1'b0;
  endtask

  // Enter, flip encoding mid-conversion, check timing and result
  task automatic run(input string tag,
                     input logic dv,
                     input logic [W-1:0] exp_n);
    logic e0;
    e0             = io.encoding;
    io.enter       = 1'b1;
    io.digit_valid = dv;
    io.digit       = 4'd7;
    tick();
    io.enter       = 1'b0;
    io.digit_valid = 1'b0;
    io.encoding    = ~e0;
    chk({tag, ".busy1"}, 32'(io.busy), 32'd1);
    tick();
    tick();
    chk({tag, ".busy3"}, 32'(io.busy), 32'd1);
    chk({tag, ".nv"}, 32'(io.valid), 32'd0);
    tick();
    chk({tag, ".valid"}, 32'(io.valid), 32'd1);
    chk({tag, ".idle"}, 32'(io.busy), 32'd0);
    chk({tag, ".n"}, 32'(io.n), 32'(exp_n));
    chk({tag, ".bcd0"}, 32'(io.bcd), 32'd0);
    chk({tag, ".cnt0"}, 32'(io.count), 32'd0);
    chk({tag, ".neg0"}, 32'(io.negative), 32'd0);
    io.encoding = e0;
    tick();
    chk({tag, ".vdrop"}, 32'(io.valid), 32'd0);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".n"}, 32'(io.n), 32'd0);
    chk({tag, ".v"}, 32'(io.valid), 32'd0);
    chk({tag, ".b"}, 32'(io.busy), 32'd0);
    chk({tag, ".bcd"}, 32'(io.bcd), 32'd0);
    chk({tag, ".c"}, 32'(io.count), 32'd0);
    chk({tag, ".ng"}, 32'(io.negative), 32'd0);
    chk({tag, ".ov"}, 32'(io.overflow), 32'd0);
  endtask

  initial begin
    io.digit       = 4'd0;
    io.digit_valid = 1'b0;
    io.negate      = 1'b0;
    io.clear       = 1'b0;
    io.enter       = 1'b0;
    io.encoding    = 1'b1;
    tick();
    tick();
    all_zero("rst");
    rst = 1'b0;
    tick();

    // 725 positive
    key(4'd7); key(4'd2); key(4'd5);
    chk("t1.bcd", 32'(io.bcd), 32'h725);
    chk("t1.cnt", 32'(io.count), 32'd3);
    run("t1", 1'b0, 11'h2D5);

    // -3 in both encodings
    key(4'd3); neg_key();
    chk("t2.neg", 32'(io.negative), 32'd1);
    run("t2a", 1'b0, 11'h7FD);
    io.encoding = 1'b0;
    key(4'd3); neg_key();
    run("t2b", 1'b0, 11'h403);

    // fourth digit dropped, sticky overflow
    key(4'd1); key(4'd0); key(4'd0);
    chk("t3.ov0", 32'(io.overflow), 32'd0);
    key(4'd0);
    chk("t3.ov1", 32'(io.overflow), 32'd1);
    chk("t3.cnt", 32'(io.count), 32'd3);
    chk("t3.bcd", 32'(io.bcd), 32'h100);
    run("t3", 1'b0, 11'd100);
    chk("t3.ovk", 32'(io.overflow), 32'd1);
    clr_key();
    chk("t3.ovc", 32'(io.overflow), 32'd0);

    // abort on second convert cycle keeps N=100
    key(4'd4); key(4'd2);
    io.enter = 1'b1;
    tick();
    io.enter = 1'b0;
    tick();
    chk("t5.busy", 32'(io.busy), 32'd1);
    io.clear = 1'b1;
    tick();
    io.clear = 1'b0;
    chk("t5.idle", 32'(io.busy), 32'd0);
    chk("t5.cnt", 32'(io.count), 32'd0);
    chk("t5.nv", 32'(io.valid), 32'd0);
    tick();
    tick();
    chk("t5.nv2", 32'(io.valid), 32'd0);
    chk("t5.n", 32'(io.n), 32'd100);

    // no negative zero, invalid digit ignored
    neg_key();
    run("t4", 1'b0, 11'd0);
    key(4'd12);
    chk("t4.cnt", 32'(io.count), 32'd0);
    chk("t4.bcd", 32'(io.bcd), 32'd0);

    // enter beats digit in same cycle; leading zeros count
    io.encoding = 1'b1;
    key(4'd0); key(4'd5);
    run("t6", 1'b1, 11'd5);
    key(4'd0); key(4'd0); key(4'd7);
    chk("t6.cnt", 32'(io.count), 32'd3);
    run("t6z", 1'b0, 11'd7);

    // clear beats enter
    key(4'd8);
    io.clear = 1'b1;
    io.enter = 1'b1;
    tick();
    io.clear = 1'b0;
    io.enter = 1'b0;
    chk("t7.busy", 32'(io.busy), 32'd0);
    chk("t7.cnt", 32'(io.count), 32'd0);
    tick();
    tick();
    tick();
    chk("t7.nv", 32'(io.valid), 32'd0);
    chk("t7.n", 32'(io.n), 32'd7);

    // async reset mid-conversion
    key(4'd9); neg_key();
    io.enter = 1'b1;
    tick();
    io.enter = 1'b0;
    chk("t8.busy", 32'(io.busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    all_zero("t8");
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    chk("t8.nv", 32'(io.valid), 32'd0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

endmodule
